l2_port_arbiter: RTL

// Shares the single L2/physical-memory line port between the icache miss path and the

---
 rtl/l2_port_arbiter.sv | 118 +++++++++++
 1 files changed

// File: rtl/l2_port_arbiter.sv
// Arbitrates the shared L2 line port between the icache miss path and the dcache
// miss/writeback path, one transaction at a time, round-robin on ties.
module l2_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_address,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_address,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,
    output logic              l2_read,
    output logic              l2_write,
    output logic [ADDR_W-1:0] l2_address,
    output logic [LINE_W-1:0] l2_wdata,
    input  logic [LINE_W-1:0] l2_rdata,
    input  logic              l2_resp,
    input  logic              clear_count,
    output logic [CNT_W-1:0]  contention_count
);

    typedef enum logic [1:0] {
        IDLE,
        GRANT_I,
        GRANT_D,
        RELEASE
    } state_t;

    state_t state, state_nxt;
    logic   last_grant_d, last_grant_d_nxt;
    logic   d_req;
    logic   contended;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign d_req     = d_read | d_write;
    assign contended = (i_read && state != GRANT_I) || (d_req && state != GRANT_D);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            last_grant_d <= 1'b0;
        end else begin
            state        <= state_nxt;
            last_grant_d <= last_grant_d_nxt;
        end
    end

    // Grant outputs and completion pulses are combinational off the registered state
    always_comb begin
        state_nxt        = state;
        last_grant_d_nxt = last_grant_d;
        l2_read          = 1'b0;
        l2_write         = 1'b0;
        l2_address       = '0;
        l2_wdata         = '0;
        i_resp           = 1'b0;
        i_rdata          = '0;
        d_resp           = 1'b0;
        d_rdata          = '0;
        case (state)
            IDLE: begin
                if (i_read && d_req)
                    state_nxt = last_grant_d ? GRANT_I : GRANT_D;
                else if (i_read)
                    state_nxt = GRANT_I;
                else if (d_req)
                    state_nxt = GRANT_D;
            end
            GRANT_I: begin
                l2_read    = 1'b1;
                l2_address = i_address;
                if (l2_resp) begin
                    i_resp           = 1'b1;
                    i_rdata          = l2_rdata;
                    last_grant_d_nxt = 1'b0;
                    state_nxt        = RELEASE;
                end
            end
            GRANT_D: begin
                // A writeback takes precedence if the dcache raises both
                l2_read    = d_read & ~d_write;
                l2_write   = d_write;
                l2_address = d_address;
                l2_wdata   = d_wdata;
                if (l2_resp) begin
                    d_resp           = 1'b1;
                    d_rdata          = l2_rdata;
                    last_grant_d_nxt = 1'b1;
                    state_nxt        = RELEASE;
                end
            end
            RELEASE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Clear wins over a same-cycle increment
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            contention_count <= '0;
        else if (clear_count)
            contention_count <= '0;
        else if (contended)
            contention_count <= sat_inc(contention_count);
    end

endmodule
